mem_arbiter: RTL and testbench

Single-port memory arbiter that sits between the pipeline's fetch stage (IF) and memory stage (DM) and the unified instruction/data memory. It is instantiated inside TOP. It serialises both requesters onto one fixed-latency memory port, holds the losing stage stalled, and returns read data with a one-cycle valid pulse. Tie-breaking is alternating, with data access preferred on the first tie after reset.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/DM memory arbiter.
// Owner encoding doubles as the last-grant flag used for tie-breaking.
package mem_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   localparam int MEM_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   // Choose the next owner; a tie goes to the port that did not win last.
   function automatic logic pick_owner(
      input logic if_req,
      input logic dm_req,
      input logic last
   );
      logic own;
      own = OWN_IF;
      if (if_req && dm_req) begin
         own = ~last;
      end else if (dm_req) begin
         own = OWN_DM;
      end
      return own;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data requests onto one fixed-latency
// memory port with alternating tie-break and one-cycle valid pulses.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_if_req,
   input  logic [ADDR_W-1:0] io_if_addr,
   output logic [XLEN-1:0]   io_if_rdata,
   output logic              io_if_valid,
   output logic              io_if_stall,
   input  logic              io_dm_req,
   input  logic              io_dm_we,
   input  logic [ADDR_W-1:0] io_dm_addr,
   input  logic [XLEN-1:0]   io_dm_wdata,
   input  logic [XLEN/8-1:0] io_dm_wmask,
   output logic [XLEN-1:0]   io_dm_rdata,
   output logic              io_dm_valid,
   output logic              io_dm_stall,
   output logic              io_mem_en,
   output logic              io_mem_we,
   output logic [ADDR_W-1:0] io_mem_addr,
   output logic [XLEN-1:0]   io_mem_wdata,
   output logic [XLEN/8-1:0] io_mem_wmask,
   input  logic [XLEN-1:0]   io_mem_rdata
);

   // Latency is clamped into what the 4-bit counter can represent.
   localparam int LAT_C =
      (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
      ((MEM_LAT < 1) ? 1 : MEM_LAT);
   localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LAT_C);

   arb_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_owner;
   logic              r_last;
   logic [XLEN-1:0]   r_if_rdata;
   logic              r_if_valid;
   logic [XLEN-1:0]   r_dm_rdata;
   logic              r_dm_valid;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [XLEN-1:0]   r_mem_wdata;
   logic [XLEN/8-1:0] r_mem_wmask;

   logic w_any_valid;
   logic w_any_req;
   logic w_grant;
   logic w_pick;
   logic w_done;

   // The completion cycle still shows the served request, so no grant then.
   assign w_any_valid = r_if_valid | r_dm_valid;
   assign w_any_req   = io_if_req | io_dm_req;
   assign w_grant     = (r_state == IDLE) & w_any_req & ~w_any_valid;
   assign w_pick      = pick_owner(io_if_req, io_dm_req, r_last);
   assign w_done      = (r_state == ACCESS) & (r_cnt == '0);

   // Arbitration FSM with the inline latency counter and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_owner     <= OWN_IF;
         r_last      <= OWN_IF;
         r_if_rdata  <= '0;
         r_if_valid  <= 1'b0;
         r_dm_rdata  <= '0;
         r_dm_valid  <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
      end else begin
         r_mem_en   <= 1'b0;
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner  <= w_pick;
                  r_mem_en <= 1'b1;
                  r_cnt    <= LAT_LD;
                  r_state  <= ACCESS;
                  if (w_pick == OWN_DM) begin
                     r_mem_we    <= io_dm_we;
                     r_mem_addr  <= io_dm_addr;
                     r_mem_wdata <= io_dm_wdata;
                     r_mem_wmask <= io_dm_wmask;
                  end else begin
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= io_if_addr;
                     r_mem_wdata <= '0;
                     r_mem_wmask <= '0;
                  end
               end
            end
            ACCESS: begin
               if (w_done) begin
                  r_last  <= r_owner;
                  r_state <= IDLE;
                  if (r_owner == OWN_DM) begin
                     r_dm_valid <= 1'b1;
                     if (!r_mem_we) begin
                        r_dm_rdata <= io_mem_rdata;
                     end
                  end else begin
                     r_if_valid <= 1'b1;
                     if (!r_mem_we) begin
                        r_if_rdata <= io_mem_rdata;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign io_if_rdata  = r_if_rdata;
   assign io_if_valid  = r_if_valid;
   assign io_if_stall  = io_if_req & ~r_if_valid;
   assign io_dm_rdata  = r_dm_rdata;
   assign io_dm_valid  = r_dm_valid;
   assign io_dm_stall  = io_dm_req & ~r_dm_valid;
   assign io_mem_en    = r_mem_en;
   assign io_mem_we    = r_mem_we;
   assign io_mem_addr  = r_mem_addr;
   assign io_mem_wdata = r_mem_wdata;
   assign io_mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checks of mem_arbiter against
// a request-level model of grant order, timing and returned data.
module tb_mem_arbiter;

   localparam int NDUT = 3;
   localparam int LATS [NDUT] = '{2, 1, 15};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_req   [NDUT];
   logic [31:0] if_addr  [NDUT];
   wire  [31:0] if_rdata [NDUT];
   wire         if_valid [NDUT];
   wire         if_stall [NDUT];
   logic        dm_req   [NDUT];
   logic        dm_we    [NDUT];
   logic [31:0] dm_addr  [NDUT];
   logic [31:0] dm_wdata [NDUT];
   logic [3:0]  dm_wmask [NDUT];
   wire  [31:0] dm_rdata [NDUT];
   wire         dm_valid [NDUT];
   wire         dm_stall [NDUT];
   wire         mem_en   [NDUT];
   wire         mem_we   [NDUT];
   wire  [31:0] mem_addr [NDUT];
   wire  [31:0] mem_wdata[NDUT];
   wire  [3:0]  mem_wmask[NDUT];
   wire  [31:0] mem_rdata[NDUT];

   function automatic logic [31:0] pat(int i);
      return (i == 4) ? 32'hDEADBEEF : 32'h5A000000 + 32'(i) * 32'h00010203;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] cur,
                                         logic [31:0] wd,
                                         logic [3:0]  m);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   for (genvar k = 0; k < NDUT; k++) begin : g
      logic [31:0] dlt [32] = '{default: '0};
      int          age = 0;
      logic [4:0]  idx;
      assign idx = mem_addr[k][6:2];
      // memory model: data is only correct on the exact latency cycle
      always @(posedge clk) begin
         if (mem_en[k]) age <= 1;
         else if (age != 0 && age < 1000) age <= age + 1;
         if (mem_en[k] && mem_we[k])
            dlt[idx] <= merge(dlt[idx] ^ pat(int'(idx)), mem_wdata[k],
                              mem_wmask[k]) ^ pat(int'(idx));
      end
      assign mem_rdata[k] = (age == LATS[k]) ? (dlt[idx] ^ pat(int'(idx)))
                                             : (32'hBAD00000 ^ 32'(age));
      mem_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(LATS[k])) u_dut (
         .clock       (clk),
         .reset       (reset),
         .io_if_req   (if_req[k]),
         .io_if_addr  (if_addr[k]),
         .io_if_rdata (if_rdata[k]),
         .io_if_valid (if_valid[k]),
         .io_if_stall (if_stall[k]),
         .io_dm_req   (dm_req[k]),
         .io_dm_we    (dm_we[k]),
         .io_dm_addr  (dm_addr[k]),
         .io_dm_wdata (dm_wdata[k]),
         .io_dm_wmask (dm_wmask[k]),
         .io_dm_rdata (dm_rdata[k]),
         .io_dm_valid (dm_valid[k]),
         .io_dm_stall (dm_stall[k]),
         .io_mem_en   (mem_en[k]),
         .io_mem_we   (mem_we[k]),
         .io_mem_addr (mem_addr[k]),
         .io_mem_wdata(mem_wdata[k]),
         .io_mem_wmask(mem_wmask[k]),
         .io_mem_rdata(mem_rdata[k])
      );
   end

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          lg_port[$];
   int          lg_cyc[$];
   logic [31:0] lg_data[$];
   int          en_cnt;
   int          stall_cnt;
   logic [31:0] en_addr, en_wdata;
   logic        en_we;
   logic [3:0]  en_wmask;
   logic [31:0] if_exp[$];
   logic [31:0] dm_exp[$];
   logic [31:0] ref_mem[32];
   logic [31:0] dm_hold;
   int          if_todo, dm_todo;
   int          exp_last;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic new_if(logic [31:0] a);
      if_addr[0] = a;
      if_req[0]  = 1'b1;
      if_exp.push_back(ref_mem[a[6:2]]);
   endtask

   task automatic new_if_rand();
      logic [31:0] a;
      a = ($urandom & 32'hFFFFFF80) | (32'($urandom_range(0, 7)) << 2);
      new_if(a);
   endtask

   task automatic new_dm(logic we, logic [31:0] a, logic [31:0] wd,
                         logic [3:0] m);
      dm_we[0]    = we;
      dm_addr[0]  = a;
      dm_wdata[0] = wd;
      dm_wmask[0] = m;
      dm_req[0]   = 1'b1;
      if (we) ref_mem[a[6:2]] = merge(ref_mem[a[6:2]], wd, m);
      else dm_hold = ref_mem[a[6:2]];
      dm_exp.push_back(dm_hold);
   endtask

   task automatic new_dm_rand();
      logic [31:0] a;
      a = ($urandom & 32'hFFFFFF80) | (32'($urandom_range(16, 31)) << 2);
      new_dm(1'($urandom), a, $urandom, 4'($urandom));
   endtask

   task automatic tick();
      logic sif, sdm;
      @(negedge clk);
      sif = if_valid[0];
      sdm = dm_valid[0];
      if (sif) begin
         lg_port.push_back(0); lg_cyc.push_back(cyc);
         lg_data.push_back(if_rdata[0]);
      end
      if (sdm) begin
         lg_port.push_back(1); lg_cyc.push_back(cyc);
         lg_data.push_back(dm_rdata[0]);
      end
      if (mem_en[0]) begin
         en_cnt++;
         en_addr = mem_addr[0]; en_we = mem_we[0];
         en_wdata = mem_wdata[0]; en_wmask = mem_wmask[0];
      end
      if (if_stall[0]) stall_cnt++;
      edge1();
      if (sif) begin
         if (if_todo > 0) begin if_todo--; new_if_rand(); end
         else if_req[0] = 1'b0;
      end
      if (sdm) begin
         if (dm_todo > 0) begin dm_todo--; new_dm_rand(); end
         else dm_req[0] = 1'b0;
      end
   endtask

   task automatic clear_obs();
      lg_port.delete(); lg_cyc.delete(); lg_data.delete();
      en_cnt = 0; stall_cnt = 0;
      if_todo = 0; dm_todo = 0;
   endtask

   // Both ports keep demand until their count is used; the rules say a
   // tie goes opposite the last winner and each access takes L+3 cycles.
   task automatic finish_phase(int c0, int n_if, int n_dm, string tag);
      int n, ri, rd, own, lat;
      logic [31:0] ed;
      lat = LATS[0];
      n = n_if + n_dm;
      for (int i = 0; i < (n + 1) * (lat + 3) + 10 && lg_port.size() < n; i++)
         tick();
      repeat (lat + 4) tick();
      chk({tag, " count"}, 32'(lg_port.size()), 32'(n));
      ri = n_if; rd = n_dm;
      for (int k = 0; k < n; k++) begin
         if (ri > 0 && rd > 0) own = 1 - exp_last;
         else own = (ri > 0) ? 0 : 1;
         if (own == 0) ri--; else rd--;
         exp_last = own;
         if (own == 0) ed = (if_exp.size() > 0) ? if_exp.pop_front() : 'x;
         else ed = (dm_exp.size() > 0) ? dm_exp.pop_front() : 'x;
         if (k < lg_port.size()) begin
            chk({tag, " port"}, 32'(lg_port[k]), 32'(own));
            chk({tag, " cycle"}, 32'(lg_cyc[k]),
                32'(c0 + lat + 2 + k * (lat + 3)));
            chk({tag, " data"}, lg_data[k], ed);
         end
      end
      chk({tag, " strobes"}, 32'(en_cnt), 32'(n));
   endtask

   task automatic start_rand(int n_if, int n_dm, string tag);
      int c0;
      clear_obs();
      c0 = cyc;
      if (n_if > 0) begin if_todo = n_if - 1; new_if_rand(); end
      if (n_dm > 0) begin dm_todo = n_dm - 1; new_dm_rand(); end
      finish_phase(c0, n_if, n_dm, tag);
   endtask

   task automatic model_reset();
      if_exp.delete(); dm_exp.delete();
      exp_last = 0; dm_hold = '0;
   endtask

   task automatic do_reset(bit check);
      reset = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         if_req[k] = 1'b0; dm_req[k] = 1'b0;
      end
      repeat (3) edge1();
      if (check) begin
         chk("rst mem_en", 32'(mem_en[0]), 0);
         chk("rst mem_we", 32'(mem_we[0]), 0);
         chk("rst mem_addr", mem_addr[0], 0);
         chk("rst mem_wdata", mem_wdata[0], 0);
         chk("rst mem_wmask", 32'(mem_wmask[0]), 0);
         chk("rst if_rdata", if_rdata[0], 0);
         chk("rst dm_rdata", dm_rdata[0], 0);
         chk("rst if_valid", 32'(if_valid[0]), 0);
         chk("rst dm_valid", 32'(dm_valid[0]), 0);
         chk("rst if_stall", 32'(if_stall[0]), 0);
         chk("rst dm_stall", 32'(dm_stall[0]), 0);
      end
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      int c0, lat;
      logic [31:0] got;
      reset = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
         dm_addr[k] = 0; dm_wdata[k] = 0; dm_wmask[k] = 0;
      end
      for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
      clear_obs();
      do_reset(1);

      clear_obs();
      c0 = cyc;
      new_if(32'h10);
      finish_phase(c0, 1, 0, "if_rd");
      chk("if_rd stall cycles", 32'(stall_cnt), 4);
      chk("if_rd mem_addr", en_addr, 32'h10);
      chk("if_rd mem_we", 32'(en_we), 0);

      do_reset(0);
      start_rand(1, 1, "tie1");
      start_rand(1, 1, "tie2");

      clear_obs();
      c0 = cyc;
      new_dm(1'b1, 32'h20, 32'h12345678, 4'hF);
      finish_phase(c0, 0, 1, "dm_wr");
      chk("dm_wr mem_we", 32'(en_we), 1);
      chk("dm_wr mem_addr", en_addr, 32'h20);
      chk("dm_wr mem_wdata", en_wdata, 32'h12345678);
      chk("dm_wr mem_wmask", 32'(en_wmask), 32'hF);
      chk("dm_wr memory", g[0].dlt[8] ^ pat(8), 32'h12345678);

      start_rand(4, 4, "alt");
      for (int r = 0; r < 4; r++)
         start_rand($urandom_range(0, 3), $urandom_range(1, 3), "mix");

      clear_obs();
      new_if_rand();
      edge1(); edge1();
      reset = 1'b0;
      if_req[0] = 1'b0;
      edge1();
      chk("abort mem_en", 32'(mem_en[0]), 0);
      chk("abort mem_addr", mem_addr[0], 0);
      chk("abort mem_wdata", mem_wdata[0], 0);
      chk("abort mem_we", 32'(mem_we[0]), 0);
      chk("abort if_rdata", if_rdata[0], 0);
      chk("abort dm_rdata", dm_rdata[0], 0);
      chk("abort if_valid", 32'(if_valid[0]), 0);
      reset = 1'b1;
      model_reset();
      clear_obs();
      repeat (8) tick();
      chk("abort no valid", 32'(lg_port.size()), 0);
      chk("abort no strobe", 32'(en_cnt), 0);
      start_rand(1, 0, "after_abort");

      for (int k = 1; k < NDUT; k++) begin
         if_addr[k] = 32'h10;
         if_req[k]  = 1'b1;
         c0 = cyc;
         lat = -1;
         got = '0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_valid[k]) begin
               lat = cyc - c0;
               got = if_rdata[k];
               break;
            end
            edge1();
         end
         edge1();
         if_req[k] = 1'b0;
         chk($sformatf("lat%0d latency", LATS[k]), 32'(lat), 32'(LATS[k] + 2));
         chk($sformatf("lat%0d data", LATS[k]), got, 32'hDEADBEEF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
